// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: one full-duplex MSB-first word per start request.
// spi_clk arrives as data from clk_div and is edge-detected in the m_clk domain.
module spi_master_ctrl #(
    parameter int DATA_W    = 8,
    parameter int SETUP_CYC = 2,
    parameter int HOLD_CYC  = 2
) (
    input  logic              m_clk,
    input  logic              rst,
    input  logic              spi_clk,
    output logic              spi_clk_en,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              ss_n,
    output logic              mosi,
    input  logic              miso
);

    localparam int CMAX = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int BW   = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_e;

    state_e            state_q, state_d;
    logic              spi_q;
    logic [DATA_W-2:0] tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic              en_q, en_d;
    logic              ss_n_q, ss_n_d;
    logic              mosi_q, mosi_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic rise, fall, setup_end, hold_end, last_fall;

    assign rise      = spi_clk & ~spi_q;
    assign fall      = ~spi_clk & spi_q;
    assign setup_end = (cnt_q == CW'(SETUP_CYC - 1));
    assign hold_end  = (cnt_q == CW'(HOLD_CYC - 1));
    assign last_fall = fall && (bit_q == BW'(DATA_W));

    always_ff @(posedge m_clk) begin
        if (rst) begin
            state_q <= IDLE;
            spi_q   <= 1'b0;
            tx_sr_q <= '0;
            rx_sr_q <= '0;
            rx_q    <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
            en_q    <= 1'b0;
            ss_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            spi_q   <= spi_clk;
            tx_sr_q <= tx_sr_d;
            rx_sr_q <= rx_sr_d;
            rx_q    <= rx_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            en_q    <= en_d;
            ss_n_q  <= ss_n_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = SETUP;
            SETUP:   if (setup_end) state_d = XFER;
            XFER:    if (last_fall) state_d = HOLD;
            HOLD:    if (hold_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_sr_d = tx_sr_q;
        rx_sr_d = rx_sr_q;
        rx_d    = rx_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        en_d    = en_q;
        ss_n_d  = ss_n_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    tx_sr_d = tx_data[DATA_W-2:0];
                    mosi_d  = tx_data[DATA_W-1];
                    ss_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            SETUP: begin
                if (setup_end) begin
                    en_d  = 1'b1;
                    bit_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            XFER: begin
                if (rise) begin
                    rx_sr_d = {rx_sr_q[DATA_W-2:0], miso};
                    bit_d   = bit_q + BW'(1);
                end else if (last_fall) begin
                    en_d   = 1'b0;
                    mosi_d = 1'b0;
                    cnt_d  = '0;
                end else if (fall && bit_q != '0) begin
                    // a fall before the first rise must not consume a bit
                    mosi_d  = tx_sr_q[DATA_W-2];
                    tx_sr_d = tx_sr_q << 1;
                end
            end
            HOLD: begin
                if (hold_end) begin
                    ss_n_d = 1'b1;
                    done_d = 1'b1;
                    busy_d = 1'b0;
                    rx_d   = rx_sr_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: ;
        endcase
    end

    assign spi_clk_en = en_q;
    assign ss_n       = ss_n_q;
    assign mosi       = mosi_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign rx_data    = rx_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl with a behavioural clk_div
// (half-period of 2 m_clk cycles) and loopback or tied-high miso.
module tb_spi_master_ctrl;

    logic       m_clk = 1'b0;
    logic       rst = 1'b1;
    logic       spi_clk;
    logic       spi_clk_en;
    logic       start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       busy, done, ss_n, mosi, miso;
    logic [7:0] rx_data;

    logic div_clk = 1'b0;
    logic ext_clk = 1'b0;
    logic dcnt = 1'b0;
    logic miso_one = 1'b0;

    int n_assert = 0;
    int n_fail = 0;

    logic        spi_prev = 1'b0;
    int          rise_n = 0;
    int          done_n = 0;
    int          mosi_hi = 0;
    logic [31:0] rise_bits = '0;

    int b_r, b_d, b_m;

    spi_master_ctrl #(.DATA_W(8), .SETUP_CYC(2), .HOLD_CYC(2)) dut (
        .m_clk(m_clk), .rst(rst), .spi_clk(spi_clk),
        .spi_clk_en(spi_clk_en), .start(start), .tx_data(tx_data),
        .busy(busy), .done(done), .rx_data(rx_data),
        .ss_n(ss_n), .mosi(mosi), .miso(miso)
    );

    always #50 m_clk = ~m_clk;

    assign spi_clk = div_clk | ext_clk;
    assign miso = miso_one ? 1'b1 : mosi;

    // clk_div model: low while disabled, toggles every 2 m_clk cycles
    always @(posedge m_clk) begin
        if (!spi_clk_en) begin
            dcnt <= 1'b0;
            div_clk <= 1'b0;
        end else if (dcnt) begin
            dcnt <= 1'b0;
            div_clk <= ~div_clk;
        end else begin
            dcnt <= 1'b1;
        end
    end

    always @(negedge m_clk) begin
        spi_prev <= spi_clk;
        if (spi_clk && !spi_prev && !ss_n) begin
            rise_n <= rise_n + 1;
            rise_bits <= {rise_bits[30:0], mosi};
        end
        if (done) done_n <= done_n + 1;
        if (mosi) mosi_hi <= mosi_hi + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge m_clk);
            if (done) seen = 1'b1;
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    task automatic start_xfer(input logic [7:0] d);
        @(negedge m_clk);
        start = 1'b1;
        tx_data = d;
        @(negedge m_clk);
        start = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge m_clk);
        chk("rst_ss_n", 32'(ss_n), 32'd1);
        chk("rst_en", 32'(spi_clk_en), 32'd0);
        chk("rst_mosi", 32'(mosi), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rx", 32'(rx_data), 32'h00);
        rst = 1'b0;

        // 1: loopback A5
        b_r = rise_n; b_d = done_n;
        start_xfer(8'hA5);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_ss_n", 32'(ss_n), 32'd0);
        wait_done("t1_done_seen");
        chk("t1_rx", 32'(rx_data), 32'hA5);
        chk("t1_busy_done", 32'(busy), 32'd0);
        chk("t1_ss_n_done", 32'(ss_n), 32'd1);
        @(negedge m_clk);
        chk("t1_done_width", 32'(done), 32'd0);
        chk("t1_mosi_bits", 32'(rise_bits[7:0]), 32'hA5);
        chk("t1_rises", 32'(rise_n - b_r), 32'd8);
        chk("t1_done_cnt", 32'(done_n - b_d), 32'd1);

        // 2: tx 00, miso tied high
        miso_one = 1'b1;
        b_r = rise_n; b_m = mosi_hi;
        start_xfer(8'h00);
        wait_done("t2_done_seen");
        chk("t2_rx", 32'(rx_data), 32'hFF);
        @(negedge m_clk);
        chk("t2_rises", 32'(rise_n - b_r), 32'd8);
        chk("t2_mosi_low", 32'(mosi_hi - b_m), 32'd0);
        miso_one = 1'b0;

        // 3: start while busy is ignored
        b_d = done_n;
        start_xfer(8'h3C);
        repeat (10) @(negedge m_clk);
        start = 1'b1;
        tx_data = 8'hC3;
        @(negedge m_clk);
        start = 1'b0;
        chk("t3_busy", 32'(busy), 32'd1);
        wait_done("t3_done_seen");
        chk("t3_rx", 32'(rx_data), 32'h3C);
        repeat (6) @(negedge m_clk);
        chk("t3_one_done", 32'(done_n - b_d), 32'd1);
        chk("t3_idle_busy", 32'(busy), 32'd0);
        chk("t3_idle_ss_n", 32'(ss_n), 32'd1);

        // 4: reset after 4th rise aborts
        b_r = rise_n; b_d = done_n;
        start_xfer(8'h5A);
        for (int i = 0; i < 100 && (rise_n - b_r) < 4; i++)
            @(negedge m_clk);
        chk("t4_reach_rise4", 32'(rise_n - b_r >= 4), 32'd1);
        rst = 1'b1;
        @(negedge m_clk);
        rst = 1'b0;
        chk("t4_ss_n", 32'(ss_n), 32'd1);
        chk("t4_en", 32'(spi_clk_en), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_rx", 32'(rx_data), 32'h00);
        chk("t4_done", 32'(done), 32'd0);
        repeat (10) @(negedge m_clk);
        chk("t4_no_done", 32'(done_n - b_d), 32'd0);
        start_xfer(8'h81);
        wait_done("t4_done_seen");
        chk("t4_rx_81", 32'(rx_data), 32'h81);

        // 5: start held high, back-to-back
        @(negedge m_clk);
        start = 1'b1;
        tx_data = 8'h12;
        @(negedge m_clk);
        chk("t5_busy", 32'(busy), 32'd1);
        tx_data = 8'h34;
        wait_done("t5_done1_seen");
        chk("t5_rx1", 32'(rx_data), 32'h12);
        chk("t5_ss_n_gap", 32'(ss_n), 32'd1);
        @(negedge m_clk);
        chk("t5_ss_n_relow", 32'(ss_n), 32'd0);
        chk("t5_busy2", 32'(busy), 32'd1);
        start = 1'b0;
        wait_done("t5_done2_seen");
        chk("t5_rx2", 32'(rx_data), 32'h34);
        repeat (4) @(negedge m_clk);
        chk("t5_idle_busy", 32'(busy), 32'd0);

        // 6: spi_clk toggling in IDLE has no effect
        b_d = done_n;
        repeat (8) begin
            @(negedge m_clk);
            ext_clk = ~ext_clk;
        end
        ext_clk = 1'b0;
        repeat (2) @(negedge m_clk);
        chk("t6_mosi", 32'(mosi), 32'd0);
        chk("t6_ss_n", 32'(ss_n), 32'd1);
        chk("t6_rx", 32'(rx_data), 32'h34);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_no_done", 32'(done_n - b_d), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
